// File: rtl/conv_kernel_sequencer.sv
// Coefficient sequencer for the 3x3 convolution filter.
// Holds kernel presets plus a user-writable custom bank. It snoops the filter's
// input handshake so kernel changes land only between frames, and it flags
// framing and length errors.
// Optional frame counter: define CONV_FRAME_COUNT_EN to build it; otherwise
// frame_count is tied to zero.
module conv_kernel_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned HEIGHT  = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mon_valid,
    input  logic               mon_ready,
    input  logic               mon_sop,
    input  logic               mon_eop,
    input  logic [1:0]         mode_req,
    input  logic               mode_req_valid,
    input  logic               coef_wr_en,
    input  logic [3:0]         coef_wr_addr,
    input  logic [7:0]         coef_wr_data,
    output logic signed [7:0]  k11,
    output logic signed [7:0]  k12,
    output logic signed [7:0]  k13,
    output logic signed [7:0]  k21,
    output logic signed [7:0]  k22,
    output logic signed [7:0]  k23,
    output logic signed [7:0]  k31,
    output logic signed [7:0]  k32,
    output logic signed [7:0]  k33,
    output logic [1:0]         active_mode,
    output logic               pending,
    output logic               in_frame,
    output logic               proto_err,
    output logic               len_err,
    output logic [COUNT_W-1:0] frame_count
);

    localparam int unsigned FRAME_LEN = WIDTH * HEIGHT;
    // One spare bit so an over-long frame cannot alias onto FRAME_LEN.
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1) + 1;
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Coefficient banks are packed row-major: element 0 = k11 ... element 8 = k33.
    localparam logic [8:0][7:0] K_IDENT = 72'h00_00_00_00_01_00_00_00_00;

    // Kernel selected by a mode; mode 3 takes the supplied custom bank.
    function automatic logic [8:0][7:0] preset(input logic [1:0] m,
                                               input logic [8:0][7:0] cust);
        logic [8:0][7:0] r;
        r = '0;
        case (m)
            2'd0: r[4] = 8'd1;
            2'd1: begin
                r[1] = 8'hFF;
                r[3] = 8'hFF;
                r[4] = 8'd5;
                r[5] = 8'hFF;
                r[7] = 8'hFF;
            end
            2'd2: begin
                r    = {9{8'hFF}};
                r[4] = 8'd8;
            end
            default: r = cust;
        endcase
        return r;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pending_q, pending_d;
    logic [1:0]       req_mode_q, req_mode_d;
    logic [1:0]       active_mode_q, active_mode_d;
    // k_q doubles as the custom active bank while mode 3 is applied.
    logic [8:0][7:0]  k_q, k_d;
    logic [8:0][7:0]  shadow_q, shadow_d;
    logic             proto_err_q, proto_err_d;
    logic             len_err_q, len_err_d;
    logic             apply;

    logic       beat, sop_beat, eop_beat, req_any;
    logic [1:0] req_mode_sel;

    // Handshake decode and the effective (latest-wins) request.
    assign beat         = mon_valid & mon_ready;
    assign sop_beat     = beat & mon_sop;
    assign eop_beat     = beat & mon_eop;
    assign req_any      = pending_q | mode_req_valid;
    assign req_mode_sel = mode_req_valid ? mode_req : req_mode_q;

    // Next-state: frame tracking, error flags, request apply and shadow writes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pending_d     = pending_q;
        req_mode_d    = req_mode_q;
        active_mode_d = active_mode_q;
        k_d           = k_q;
        shadow_d      = shadow_q;
        proto_err_d   = proto_err_q;
        len_err_d     = len_err_q;
        apply         = 1'b0;
        cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (sop_beat) begin
                    cnt_d   = CNT_W'(1);
                    state_d = mon_eop ? ST_IDLE : ST_ACTIVE;
                    if (mon_eop && (FRAME_LEN != 32'd1)) len_err_d = 1'b1;
                end else begin
                    apply = req_any;
                end
            end
            ST_ACTIVE: begin
                if (sop_beat) begin
                    proto_err_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                    if (mon_eop) begin
                        state_d = ST_IDLE;
                        if (FRAME_LEN != 32'd1) len_err_d = 1'b1;
                    end
                end else if (eop_beat) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_inc;
                    if (cnt_inc != FRAME_LEN_C) len_err_d = 1'b1;
                    apply   = req_any;
                end else if (beat) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (apply) begin
            active_mode_d = req_mode_sel;
            k_d           = preset(req_mode_sel, shadow_q);
            pending_d     = 1'b0;
        end else begin
            pending_d  = req_any;
            req_mode_d = req_mode_sel;
        end

        if (coef_wr_en && (coef_wr_addr < 4'd9)) begin
            shadow_d[coef_wr_addr] = coef_wr_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            req_mode_q    <= 2'd0;
            active_mode_q <= 2'd0;
            k_q           <= K_IDENT;
            shadow_q      <= K_IDENT;
            proto_err_q   <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            req_mode_q    <= req_mode_d;
            active_mode_q <= active_mode_d;
            k_q           <= k_d;
            shadow_q      <= shadow_d;
            proto_err_q   <= proto_err_d;
            len_err_q     <= len_err_d;
        end
    end

`ifdef CONV_FRAME_COUNT_EN
    logic [COUNT_W-1:0] frame_count_q, frame_count_d;

    // Count aborted frames (SOP while active) and completed frames (EOP).
    always_comb begin
        frame_count_d = frame_count_q;
        if (sop_beat && (state_q == ST_ACTIVE)) begin
            frame_count_d = frame_count_d + COUNT_W'(1);
        end
        if (eop_beat && ((state_q == ST_ACTIVE) || mon_sop)) begin
            frame_count_d = frame_count_d + COUNT_W'(1);
        end
    end

    // Wrapping frame counter register.
    always_ff @(posedge clk) begin
        if (reset) frame_count_q <= '0;
        else       frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

    assign k11         = k_q[0];
    assign k12         = k_q[1];
    assign k13         = k_q[2];
    assign k21         = k_q[3];
    assign k22         = k_q[4];
    assign k23         = k_q[5];
    assign k31         = k_q[6];
    assign k32         = k_q[7];
    assign k33         = k_q[8];
    assign active_mode = active_mode_q;
    assign pending     = pending_q;
    assign in_frame    = (state_q == ST_ACTIVE);
    assign proto_err   = proto_err_q;
    assign len_err     = len_err_q;

endmodule
